// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared region constants, requester IDs and fault codes
package dmem_port_arbiter_pkg;

  localparam logic [7:0] DATA_BASE  = 8'd128;
  localparam logic [7:0] DATA_SPAN  = 8'd96;
  localparam logic [7:0] STACK_BASE = 8'd224;
  localparam logic [7:0] STACK_TOP  = 8'd255;

  typedef enum logic [1:0] {
    RID_FETCH = 2'd0,
    RID_DATA  = 2'd1,
    RID_STACK = 2'd2
  } rid_e;

  typedef enum logic [1:0] {
    FC_NONE  = 2'd0,
    FC_RANGE = 2'd1,
    FC_OVF   = 2'd2,
    FC_UNF   = 2'd3
  } fault_e;

  // Modulo-3 add for the round-robin pointer.
  function automatic logic [1:0] rr_add(input logic [1:0] p, input logic [1:0] n);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, n};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - requester, memory and status bundle of the data memory arbiter
interface dmem_port_arbiter_if;
  logic       f_req;
  logic [7:0] f_addr;
  logic       f_gnt;
  logic       d_req;
  logic       d_we;
  logic [7:0] d_addr;
  logic [7:0] d_wdata;
  logic       d_gnt;
  logic       s_req;
  logic       s_push;
  logic [7:0] s_wdata;
  logic       s_gnt;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       rvalid;
  logic [1:0] rid;
  logic [7:0] rdata;
  logic [7:0] sp;
  logic       fault;
  logic [1:0] fault_code;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, s_req, s_push, s_wdata, mem_rdata,
    output f_gnt, d_gnt, s_gnt, mem_en, mem_we, mem_addr, mem_wdata,
           rvalid, rid, rdata, sp, fault, fault_code
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, s_req, s_push, s_wdata, mem_rdata,
    input  f_gnt, d_gnt, s_gnt, mem_en, mem_we, mem_addr, mem_wdata,
           rvalid, rid, rdata, sp, fault, fault_code
  );
endinterface

// File: rtl/dmem_port_arbiter_stack_ptr_unit.sv
// rtl/dmem_port_arbiter_stack_ptr_unit.sv - stack pointer, push/pop address and bound checks
module stack_ptr_unit
  import dmem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       gnt_i,
  input  logic       push_i,
  output logic [7:0] sp_o,
  output logic [7:0] addr_o,
  output logic       ovf_o,
  output logic       unf_o
);

  logic [7:0] sp_q, sp_d;

  assign ovf_o  = (sp_q < STACK_BASE);
  assign unf_o  = (sp_q == STACK_TOP);
  // SP points at the next free slot: push writes at SP, pop reads SP+1.
  assign addr_o = push_i ? sp_q : sp_q + 8'd1;
  assign sp_o   = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (gnt_i && push_i && !ovf_o) sp_d = sp_q - 8'd1;
    if (gnt_i && !push_i && !unf_o) sp_d = sp_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sp_q <= STACK_TOP;
    else      sp_q <= sp_d;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin sharing of the 256x8 data memory between fetch, load/store and stack
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
(
  input logic clk,
  input logic rst,
  dmem_port_arbiter_if.slave bus
);

  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic       gnt_any;
  logic [1:0] gnt_idx, cand;
  logic       cand_req;

  logic       rvalid_q, rvalid_d;
  logic [1:0] rid_q, rid_d;
  logic       zero_q, zero_d;
  logic       fault_q, fault_d;
  logic [1:0] code_q, code_d;

  logic       stk_gnt, stk_ovf, stk_unf;
  logic [7:0] stk_addr;
  logic       d_in_range;

  // Grants are forced low while reset is held so nothing is issued to memory.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = rr_ptr_q;
    cand     = rr_ptr_q;
    cand_req = 1'b0;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        cand = rr_add(rr_ptr_q, 2'(i));
        case (cand)
          2'd0:    cand_req = bus.f_req;
          2'd1:    cand_req = bus.d_req;
          2'd2:    cand_req = bus.s_req;
          default: cand_req = 1'b0;
        endcase
        if (!gnt_any && cand_req) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign rr_ptr_d   = gnt_any ? rr_add(gnt_idx, 2'd1) : rr_ptr_q;
  assign bus.f_gnt  = gnt_any && (gnt_idx == RID_FETCH);
  assign bus.d_gnt  = gnt_any && (gnt_idx == RID_DATA);
  assign stk_gnt    = gnt_any && (gnt_idx == RID_STACK);
  assign bus.s_gnt  = stk_gnt;
  assign d_in_range = (bus.d_addr < DATA_SPAN);

  stack_ptr_unit u_stack_ptr_unit (
    .clk    (clk),
    .rst    (rst),
    .gnt_i  (stk_gnt),
    .push_i (bus.s_push),
    .sp_o   (bus.sp),
    .addr_o (stk_addr),
    .ovf_o  (stk_ovf),
    .unf_o  (stk_unf)
  );

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 8'd0;
    bus.mem_wdata = 8'd0;
    rvalid_d      = 1'b0;
    rid_d         = rid_q;
    zero_d        = 1'b0;
    fault_d       = 1'b0;
    code_d        = FC_NONE;
    if (gnt_any) begin
      case (gnt_idx)
        RID_FETCH: begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = bus.f_addr;
          rvalid_d     = 1'b1;
          rid_d        = RID_FETCH;
        end
        RID_DATA: begin
          if (!bus.d_we) begin
            rvalid_d = 1'b1;
            rid_d    = RID_DATA;
          end
          if (d_in_range) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = DATA_BASE + bus.d_addr;
            bus.mem_wdata = bus.d_we ? bus.d_wdata : 8'd0;
          end else begin
            fault_d = 1'b1;
            code_d  = FC_RANGE;
            zero_d  = 1'b1;
          end
        end
        RID_STACK: begin
          if (bus.s_push) begin
            if (!stk_ovf) begin
              bus.mem_en    = 1'b1;
              bus.mem_we    = 1'b1;
              bus.mem_addr  = stk_addr;
              bus.mem_wdata = bus.s_wdata;
            end else begin
              fault_d = 1'b1;
              code_d  = FC_OVF;
            end
          end else begin
            rvalid_d = 1'b1;
            rid_d    = RID_STACK;
            if (!stk_unf) begin
              bus.mem_en   = 1'b1;
              bus.mem_addr = stk_addr;
            end else begin
              fault_d = 1'b1;
              code_d  = FC_UNF;
              zero_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= 2'd0;
      rvalid_q <= 1'b0;
      rid_q    <= 2'd0;
      zero_q   <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      zero_q   <= zero_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

  // The macro returns data the cycle after mem_en, which lines up with rvalid_q.
  assign bus.rdata      = (rvalid_q && !zero_q) ? bus.mem_rdata : 8'd0;
  assign bus.rvalid     = rvalid_q;
  assign bus.rid        = rid_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [7:0] mem [256];
  logic [7:0] mem_rd_q;

  dmem_port_arbiter_if bus();

  dmem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
      mem_rd_q <= 8'd0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            mem_rd_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = mem_rd_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.f_req = 1'b0; bus.d_req = 1'b0; bus.s_req = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.f_req = 1'b0; bus.f_addr = 8'd0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 8'd0; bus.d_wdata = 8'd0;
    bus.s_req = 1'b0; bus.s_push = 1'b0; bus.s_wdata = 8'd0;
    rst = 1'b0;

    // Reset state, with a request present that must not be granted
    bus.f_req = 1'b1;
    tick(); tick();
    chk("rst_sp", bus.sp, 255);
    chk("rst_f_gnt", bus.f_gnt, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_rdata", bus.rdata, 0);
    idle();
    rst = 1'b1;
    #1;
    chk("idle_mem_en", bus.mem_en, 0);
    chk("idle_gnts", {bus.f_gnt, bus.d_gnt, bus.s_gnt}, 0);
    tick();

    // Round-robin from rr_ptr = 0: fetch, data, stack, fetch
    bus.f_req = 1'b1; bus.f_addr = 8'd3;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'd0;
    bus.s_req = 1'b1; bus.s_push = 1'b0;
    #1;
    chk("rr0_gnts", {bus.s_gnt, bus.d_gnt, bus.f_gnt}, 3'b001);
    chk("rr0_mem_addr", bus.mem_addr, 3);
    tick();
    chk("rr1_gnts", {bus.s_gnt, bus.d_gnt, bus.f_gnt}, 3'b010);
    chk("rr1_mem_addr", bus.mem_addr, 128);
    chk("rr1_rvalid_rid", {bus.rvalid, bus.rid}, {1'b1, 2'd0});
    tick();
    chk("rr2_gnts", {bus.s_gnt, bus.d_gnt, bus.f_gnt}, 3'b100);
    chk("rr2_mem_en", bus.mem_en, 0);
    chk("rr2_rvalid_rid", {bus.rvalid, bus.rid}, {1'b1, 2'd1});
    tick();
    chk("rr3_gnts", {bus.s_gnt, bus.d_gnt, bus.f_gnt}, 3'b001);
    chk("rr3_rvalid_rid", {bus.rvalid, bus.rid}, {1'b1, 2'd2});
    chk("rr3_fault", {bus.fault, bus.fault_code}, {1'b1, 2'd3});
    chk("rr3_rdata", bus.rdata, 0);
    chk("rr3_sp", bus.sp, 255);
    idle();
    tick();

    // Store d_addr=10 data 0x5A
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'd10; bus.d_wdata = 8'h5A;
    #1;
    chk("st_gnt", bus.d_gnt, 1);
    chk("st_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 1'b1, 8'd138, 8'h5A});
    tick();
    idle();
    #1;
    chk("st_no_rvalid", bus.rvalid, 0);
    tick();

    // Load it back
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'd10;
    #1;
    chk("ld_mem", {bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr}, {1'b1, 1'b1, 1'b0, 8'd138});
    tick();
    idle();
    #1;
    chk("ld_resp", {bus.rvalid, bus.rid, bus.rdata}, {1'b1, 2'd1, 8'h5A});
    chk("ld_no_fault", bus.fault, 0);
    tick();

    // Push 0x11, 0x22
    bus.s_req = 1'b1; bus.s_push = 1'b1; bus.s_wdata = 8'h11;
    #1;
    chk("push1_mem", {bus.s_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 1'b1, 1'b1, 8'd255, 8'h11});
    tick();
    bus.s_wdata = 8'h22;
    #1;
    chk("push2_mem", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 8'd254, 8'h22});
    tick();
    chk("push_sp", bus.sp, 253);

    // Pops
    bus.s_push = 1'b0;
    #1;
    chk("pop1_mem", {bus.mem_en, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 8'd254});
    tick();
    chk("pop1_resp", {bus.rvalid, bus.rid, bus.rdata}, {1'b1, 2'd2, 8'h22});
    chk("pop1_sp", bus.sp, 254);
    #1;
    chk("pop2_addr", bus.mem_addr, 255);
    tick();
    chk("pop2_resp", {bus.rvalid, bus.rid, bus.rdata}, {1'b1, 2'd2, 8'h11});
    chk("pop2_sp", bus.sp, 255);
    #1;
    chk("pop3_gnt_en", {bus.s_gnt, bus.mem_en}, {1'b1, 1'b0});
    tick();
    idle();
    #1;
    chk("pop3_resp", {bus.rvalid, bus.rdata, bus.fault, bus.fault_code}, {1'b1, 8'd0, 1'b1, 2'd3});
    chk("pop3_sp", bus.sp, 255);
    tick();

    // Fill the stack, then overflow
    bus.s_req = 1'b1; bus.s_push = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.s_wdata = 8'(i + 1);
      tick();
    end
    chk("fill_sp", bus.sp, 223);
    chk("fill_mem224", mem[224], 32);
    bus.s_wdata = 8'hEE;
    #1;
    chk("ovf_gnt_en", {bus.s_gnt, bus.mem_en}, {1'b1, 1'b0});
    tick();
    idle();
    #1;
    chk("ovf_fault", {bus.fault, bus.fault_code}, {1'b1, 2'd2});
    chk("ovf_no_rvalid", bus.rvalid, 0);
    chk("ovf_sp", bus.sp, 223);
    chk("ovf_mem223", mem[223], 0);
    tick();
    chk("fault_pulse", bus.fault, 0);

    // Data range boundaries
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'd95; bus.d_wdata = 8'h77;
    #1;
    chk("st95_mem", {bus.mem_en, bus.mem_addr}, {1'b1, 8'd223});
    tick();
    bus.d_we = 1'b0; bus.d_addr = 8'd96;
    #1;
    chk("ld96_gnt_en", {bus.d_gnt, bus.mem_en}, {1'b1, 1'b0});
    tick();
    idle();
    #1;
    chk("ld96_resp", {bus.rvalid, bus.rid, bus.rdata}, {1'b1, 2'd1, 8'd0});
    chk("ld96_fault", {bus.fault, bus.fault_code}, {1'b1, 2'd1});
    tick();

    // Reset asserted in the grant cycle of a load
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'd10;
    #1;
    chk("rmid_gnt", bus.d_gnt, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rmid_sp_async", bus.sp, 255);
    chk("rmid_gnt_off", bus.d_gnt, 0);
    tick();
    chk("rmid_no_rvalid", bus.rvalid, 0);
    chk("rmid_no_fault", bus.fault, 0);
    idle();
    rst = 1'b1;
    tick();
    chk("rmid_after", {bus.rvalid, bus.sp}, {1'b0, 8'd255});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
